// File: rtl/data_mem_responder.sv
// Wait-state memory responder: captures one load/store per Req, answers with a
// one-cycle Ack after WAIT_CYCLES wait states, backed by an internal word RAM.
module data_mem_responder #(
  parameter int          ADDR_BITS   = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0400,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        WrEn,
  input  logic        ByteAcc,
  input  logic [31:0] Addr,
  input  logic [31:0] WrData,
  output logic        Ready,
  output logic        Ack,
  output logic [31:0] RdData,
  output logic        Err
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  typedef struct packed {
    logic        wr;
    logic        byte_acc;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  req_t            cap, live, cur;
  logic [31:0]     mem [DEPTH];

  logic [31:0]          off;
  logic [1:0]           lane;
  logic [4:0]           sh;
  logic [ADDR_BITS-1:0] idx;
  logic                 err_c;
  logic [31:0]          word, merged, wr_word, rd_c;
  logic                 go;

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (Req) state_n = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (cnt == '0) state_n = S_RESP;
      S_RESP: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    Ready = (state == S_IDLE);
    Ack   = (state == S_RESP);
  end

  always_ff @(posedge Clk) begin
    if (Reset)
      cnt <= '0;
    else if (state == S_IDLE && Req)
      cnt <= CNT_INIT;
    else if (state == S_WAIT && cnt != '0)
      cnt <= cnt - 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (state == S_IDLE && Req) cap <= live;
  end

  // With zero wait states the access runs on the capture edge itself
  always_comb begin
    live = '{wr: WrEn, byte_acc: ByteAcc, addr: Addr, wdata: WrData};
    cur  = (state == S_IDLE) ? live : cap;
  end

  always_comb begin
    off   = cur.addr - BASE_ADDR;
    lane  = off[1:0];
    sh    = {lane, 3'b000};
    idx   = off[ADDR_BITS+1:2];
    err_c = (cur.addr < BASE_ADDR)
          | (off[31:ADDR_BITS+2] != '0)
          | (!cur.byte_acc && lane != 2'd0);
    word   = mem[idx];
    merged = (word & ~(32'hFF << sh))
           | ({24'b0, cur.wdata[7:0]} << sh);
    wr_word = cur.byte_acc ? merged : cur.wdata;
    if (err_c)             rd_c = '0;
    else if (cur.wr)       rd_c = wr_word;
    else if (cur.byte_acc) rd_c = {24'b0, word[sh +: 8]};
    else                   rd_c = word;
    go = (state_n == S_RESP);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      RdData <= '0;
      Err    <= 1'b0;
    end else if (go) begin
      RdData <= rd_c;
      Err    <= err_c;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset && go && cur.wr && !err_c) mem[idx] <= wr_word;
  end

endmodule
